// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ write-domain requesters.
// Latency: req in IDLE at cycle n -> gnt and first possible wen in cycle n+1; one word/cycle in BURST.
// Backpressure: full gates wen combinationally; full-stall cycles hold the grant and do not count.
//
// Ports:
//   wclk      write-domain clock, all state on rising edge
//   reset     asynchronous active-low reset
//   req       per-requester write request (held while data pending)
//   req_data  packed requester data, requester i on [i*DW +: DW]
//   full      FIFO full flag (write-domain synchronized)
//   gnt       one-hot registered grant, zero when idle
//   ack       one-hot, requester's word written this cycle
//   wen       FIFO write enable
//   wdata     FIFO write data (zero when wen=0)
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                 wclk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 full,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 wen,
    output logic [DW-1:0]        wdata
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam logic [GW-1:0]   LAST_RST = GW'(NREQ - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(BURST);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   w_g_nxt;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_last_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    // Blocks grants on the first edge after reset release, so the earliest
    // grant lands on the second rising edge.
    logic            r_arm;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;
    logic            w_req_g;
    logic [DW-1:0]   w_data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = req_data[gi*DW +: DW];
    end

    assign w_req_g = req[r_g];
    assign wen     = (r_state == S_BURST) && w_req_g && !full;
    assign wdata   = wen ? w_data_arr[r_g] : '0;
    assign ack     = wen ? r_gnt : '0;
    assign gnt     = r_gnt;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx     = 0;
        w_idx   = '0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(r_last) + k) % NREQ;
            w_idx = GW'(idx);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (r_arm && w_found) begin
                    w_state_nxt = S_BURST;
                    w_g_nxt     = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = ONE_HOT0 << w_pick;
                end
            end
            S_BURST: begin
                if (!w_req_g) begin
                    // Early release: no write this cycle.
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (wen) begin
                    if ((r_cnt + CW'(1)) == CNT_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                // else: full stall, hold everything
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_arm   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with a write scoreboard.
// Each expected write carries its cycle, requester and data word.
// Requesters advance their data word on each ack, as a real requester would.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic                wclk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;
    logic                full;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic                wen;
    logic [DW-1:0]       wdata;

    int word     [NREQ];
    int exp_word [NREQ];
    int cyc      = 0;
    int n_checks = 0;
    int n_errs   = 0;
    logic [NREQ-1:0] ack_last = '0;

    typedef struct {
        int             c;
        int             r;
        logic [DW-1:0]  d;
    } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;
    logic [NREQ-1:0] mon_oh;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wclk     (wclk),
        .reset    (rst_n),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .ack      (ack),
        .wen      (wen),
        .wdata    (wdata)
    );

    always #5 wclk = ~wclk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++)
            req_data[i*DW +: DW] = DW'(i*16 + word[i]);
    end

    // Monitor / scoreboard checker.
    always @(negedge wclk) begin
        ack_last = ack;
        if (rst_n === 1'b1) begin
            n_checks++;
            if (!$onehot0(gnt) || !$onehot0(ack) || (wen !== (ack != '0)) ||
                (wen === 1'b1 && full === 1'b1) || (wen !== 1'b1 && wdata !== '0)) begin
                n_errs++;
                $display("FAIL invariant cyc=%0d gnt=%b ack=%b wen=%b full=%b wdata=%h",
                         cyc, gnt, ack, wen, full, wdata);
            end
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                n_errs++;
                $display("FAIL missed_write cyc=%0d: no write seen, required req %0d data %h at cyc %0d",
                         cyc, mon_e.r, mon_e.d, mon_e.c);
            end
            if (wen === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL unexpected_write cyc=%0d ack=%b wdata=%h, required no write",
                             cyc, ack, wdata);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = NREQ'(1) << mon_e.r;
                    if (mon_e.c != cyc || ack !== mon_oh || wdata !== mon_e.d) begin
                        n_errs++;
                        $display("FAIL write cyc=%0d ack=%b wdata=%h, required cyc=%0d ack=%b wdata=%h",
                                 cyc, ack, wdata, mon_e.c, mon_oh, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (ack_last[i]) word[i]++;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk_gnt(input string nm, input logic [NREQ-1:0] e);
        n_checks++;
        if (gnt !== e) begin
            n_errs++;
            $display("FAIL %s cyc=%0d gnt=%b required %b", nm, cyc, gnt, e);
        end
    endtask

    task automatic chk_zero(input string nm);
        n_checks++;
        if (gnt !== '0 || wen !== 1'b0 || ack !== '0 || wdata !== '0) begin
            n_errs++;
            $display("FAIL %s gnt=%b wen=%b ack=%b wdata=%h required all zero",
                     nm, gnt, wen, ack, wdata);
        end
    endtask

    task automatic push(input int c, input int r);
        exp_t e;
        e.c = c;
        e.r = r;
        e.d = DW'(r*16 + exp_word[r]);
        exp_q.push_back(e);
        exp_word[r]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        #1;
        chk_zero("reset_outputs");
        go(cyc + 2);
        rst_n = 1'b1;
        go(cyc + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            word[i]     = 0;
            exp_word[i] = 0;
        end

        // Single requester 2: two back-to-back bursts with one bubble.
        do_reset();
        n   = cyc;
        req = 4'b0100;
        for (int k = 1; k <= 4; k++) push(n + k, 2);
        for (int k = 6; k <= 9; k++) push(n + k, 2);
        go(n + 1);  chk_gnt("single_grant", 4'b0100);
        go(n + 4);  chk_gnt("single_beat4", 4'b0100);
        go(n + 5);  chk_gnt("single_bubble", 4'b0000);
        go(n + 6);  chk_gnt("single_regrant", 4'b0100);
        go(n + 10); req = '0; chk_gnt("single_end", 4'b0000);
        go(n + 12);

        // Fairness: all requesting, order 0,1,2,3,0.
        do_reset();
        n   = cyc;
        req = 4'b1111;
        for (int b = 0; b < 5; b++)
            for (int k = 1; k <= 4; k++) push(n + 5*b + k, b % 4);
        for (int b = 0; b < 5; b++) begin
            go(n + 5*b + 1); chk_gnt("fair_grant", NREQ'(1) << (b % 4));
            go(n + 5*b + 5); chk_gnt("fair_bubble", 4'b0000);
        end
        req = '0;
        go(n + 27);

        // Full stall on burst cycles 2-3 of requester 1.
        do_reset();
        n   = cyc;
        req = 4'b0010;
        push(n + 1, 1); push(n + 4, 1); push(n + 5, 1); push(n + 6, 1);
        go(n + 1); chk_gnt("stall_grant", 4'b0010);
        go(n + 2); full = 1'b1; chk_gnt("stall_hold1", 4'b0010);
        go(n + 3); chk_gnt("stall_hold2", 4'b0010);
        go(n + 4); full = 1'b0;
        go(n + 6); chk_gnt("stall_last", 4'b0010);
        go(n + 7); chk_gnt("stall_end", 4'b0000); req = '0;
        go(n + 9);

        // Early release of 0 after 2 beats, then 3; then 0 ahead of 1.
        do_reset();
        n   = cyc;
        req = 4'b1001;
        push(n + 1, 0); push(n + 2, 0);
        for (int k = 5; k <= 8; k++) push(n + k, 3);
        go(n + 1); chk_gnt("early_grant0", 4'b0001);
        go(n + 3); req = 4'b1000; chk_gnt("early_drop", 4'b0001);
        go(n + 4); chk_gnt("early_idle", 4'b0000);
        go(n + 5); chk_gnt("early_grant3", 4'b1000);
        go(n + 9); chk_gnt("early_end3", 4'b0000); req = 4'b0011;
        for (int k = 10; k <= 13; k++) push(n + k, 0);
        for (int k = 15; k <= 18; k++) push(n + k, 1);
        go(n + 10); chk_gnt("wrap_grant0", 4'b0001);
        go(n + 15); chk_gnt("wrap_grant1", 4'b0010);
        go(n + 19); req = '0; chk_gnt("wrap_end", 4'b0000);
        go(n + 21);

        // Reset during beat 2 of requester 0; pointer must return to 0.
        do_reset();
        n   = cyc;
        req = 4'b0001;
        push(n + 1, 0);
        go(n + 1); chk_gnt("rstmid_grant", 4'b0001);
        go(n + 2);
        rst_n = 1'b0;
        #1;
        chk_zero("rstmid_outputs");
        req = 4'b0101;
        go(n + 4); rst_n = 1'b1;
        go(n + 5); chk_gnt("rstmid_no_early_grant", 4'b0000);
        for (int k = 6; k <= 9; k++) push(n + k, 0);
        go(n + 6); chk_gnt("rstmid_first_grant0", 4'b0001);
        go(n + 10); chk_gnt("rstmid_end", 4'b0000); req = '0;
        go(n + 12);

        // Full already high at grant, released 3 cycles later.
        do_reset();
        n    = cyc;
        req  = 4'b1000;
        full = 1'b1;
        for (int k = 4; k <= 7; k++) push(n + k, 3);
        go(n + 1); chk_gnt("fullgnt_grant", 4'b1000);
        go(n + 3); chk_gnt("fullgnt_hold", 4'b1000);
        go(n + 4); full = 1'b0;
        go(n + 8); chk_gnt("fullgnt_end", 4'b0000); req = '0;
        go(n + 10);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errs++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the asynchronous FIFO among several requesters in the write clock domain. It grants one requester at a time for a bounded burst and multiplexes that requester's data onto the FIFO write port. It gates writes with the FIFO `full` flag so that no write is issued while full. It sits directly in front of the FIFO's `wdata`/`wen` inputs and runs entirely on `wclk`.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `DW`, 8: data width, matches FIFO `wdata`
- `BURST`, 4: maximum accepted beats per grant (1..15)

- `wclk`  in  1  write-domain clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; one clock (`wclk`) only
- `req`  in  NREQ  per-requester write request; held high while data is pending
- `req_data`  in  NREQ*DW  packed data; requester i on bits [i*DW +: DW]
- `full`  in  1  FIFO full flag (write-domain synchronized)
- `gnt`  out  NREQ  one-hot registered grant; all-zero when idle
- `ack`  out  NREQ  one-hot; `ack[i]`=1 means requester i's word was written this cycle
- `wen`  out  1  FIFO write enable
- `wdata`  out  DW  FIFO write data

## Operation
- Two states:
  - IDLE: `gnt`=0.
  - BURST: `gnt` is one-hot, index `g`.
- Registered state:
  - state
  - `g`
  - beat counter `cnt`, width clog2(BURST+1)
  - round-robin pointer `last`
- IDLE, any `req` high:
  - Pick the first i with `req[i]`=1, searching (last+1), (last+2), ... modulo NREQ.
  - Next edge: state=BURST, `g`=i, `gnt`=1<<i, `last`=i, `cnt`=0.
- IDLE, no `req`: remain in IDLE.
- BURST, combinational outputs:
  - `wen` = `req[g]` & ~`full`
  - `wdata` = `req_data[g]` when `wen`=1, else 0
  - `ack` = `gnt` when `wen`=1, else 0
- BURST, per edge:
  - If `wen`: `cnt`++. If the new `cnt` == BURST, next state=IDLE.
  - If `req[g]`=0: next state=IDLE (early release, no write that cycle).
  - If `req[g]`=1 and `full`=1: stall. Hold state and `cnt`; full-stall cycles do not count toward BURST. There is no timeout.
- Leaving BURST always passes through one IDLE cycle: one-cycle bubble between grants.
- `req[j]`, j≠g, are ignored during BURST.
- `last` wraps modulo NREQ. Reset value NREQ-1, so requester 0 has first priority.
- Requesters must keep `req_data` stable while `req` is high and their `ack` is low. A requester advances to its next word on each `ack`.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `gnt`=0, `cnt`=0, `last`=NREQ-1
  - `wen`=0, `ack`=0, `wdata`=0, immediately
  - Reset asserted mid-burst aborts the burst at once; the in-flight word is not written.
- Release is synchronous: the first grant can occur at the second `wclk` rising edge after `reset` rises.
- Grant latency: `req` high in IDLE at cycle n -> `gnt` high and first possible `wen` in cycle n+1.
- Throughput in BURST with `full`=0 and `req[g]`=1: one word per cycle.
- A BURST-beat burst occupies BURST cycles, plus one IDLE cycle, plus stall cycles.
- `full` affects `wen` combinationally in the same cycle. The arbiter never asserts `wen` while `full`=1.
- At most one bit of `gnt`/`ack` is high. `wen`=1 iff exactly one `ack` bit is high.

## Test plan
- Single requester, NREQ=4, BURST=4:
  - Stimulus: `req[2]` held high, `full`=0.
  - Response: `gnt`=0100 cycles 1-4; `wen`=1 with `wdata`=req_data[2] cycles 1-4; `gnt`=0 cycle 5; regrant of 2 in cycle 6.
- Fairness:
  - Stimulus: all four `req` held high continuously.
  - Response: grant order 0,1,2,3,0; each holds 4 beats; one idle cycle between grants.
- Full stall:
  - Stimulus: `req[1]` high; `full`=1 during cycles 2-3 of the burst.
  - Response: `wen`=0 and `ack`=0 in those cycles; `gnt` held; burst still delivers exactly 4 writes, ending one cycle later per stall cycle.
- Early release:
  - Stimulus: `req[0]` drops after 2 accepted beats; `req[3]` is pending.
  - Response: 2 writes from 0; idle next cycle; then `gnt`=1000.
  - Follow-up: with `last`=3, requester 0 raises `req` while `req[1]` is also high -> 0 is granted before 1.
- Reset mid-burst:
  - Stimulus: pull `reset` low during beat 2.
  - Response: `gnt`, `wen`, `ack`, `wdata` zero immediately. After release, the first grant goes to requester 0 when `req[0]` and `req[2]` are both high.
- Full at grant:
  - Stimulus: `full`=1 when the grant issues; `full` deasserts 3 cycles later.
  - Response: zero writes during those 3 cycles, then 4 consecutive writes.
